// File: rtl/uart_baud_gen.sv
// Oversample strobe generator for the 8051 serial port.
// Also holds the TH1 auto-reload baud timer and the rxd synchronizer.
module uart_baud_gen #(
    parameter logic [7:0] TH1_ADDR = 8'h8D,
    parameter int PRESCALE = 12,
    parameter int M0_DIV = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ab,
    input  logic [7:0] db_w,
    input  logic       wrn,
    input  logic [7:0] scon,
    input  logic       smod,
    input  logic       tr1,
    input  logic       rxd,
    output logic       rxd_s,
    output logic       div_clk,
    output logic       t1_ovf,
    output logic [7:0] th1
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MW = (M0_DIV > 1) ? $clog2(M0_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [MW-1:0] M0_LAST = MW'(M0_DIV - 1);

    logic          sync1;
    logic [1:0]    sm;
    logic [1:0]    sm_q;
    logic          smod_q;
    logic          chg;
    logic [MW-1:0] m0_cnt;
    logic [1:0]    m2_cnt;
    logic [1:0]    m2_last;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    tl;
    logic          tog;
    logic          tick;
    logic          scon_unused;

    assign sm          = scon[7:6];
    assign scon_unused = ^scon[5:0];
    assign chg         = (sm != sm_q) || (smod != smod_q);
    assign m2_last     = smod ? 2'd1 : 2'd3;
    assign tick        = tr1 && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            rxd_s   <= 1'b1;
            sm_q    <= 2'b00;
            smod_q  <= 1'b0;
            th1     <= 8'h00;
            tl      <= 8'h00;
            m0_cnt  <= '0;
            m2_cnt  <= 2'd0;
            pre_cnt <= '0;
            tog     <= 1'b0;
            div_clk <= 1'b0;
            t1_ovf  <= 1'b0;
        end else begin
            sync1   <= rxd;
            rxd_s   <= sync1;
            sm_q    <= sm;
            smod_q  <= smod;
            div_clk <= 1'b0;
            t1_ovf  <= 1'b0;
            if (!wrn && (ab == TH1_ADDR)) begin
                th1 <= db_w;
            end
            // A mode change restarts every divider so no runt strobe escapes
            if (chg) begin
                m0_cnt  <= '0;
                m2_cnt  <= 2'd0;
                pre_cnt <= '0;
                tog     <= 1'b0;
                tl      <= th1;
            end else begin
                unique case (sm)
                    2'b00: begin
                        m0_cnt  <= (m0_cnt == M0_LAST) ? '0 : m0_cnt + 1'b1;
                        div_clk <= (m0_cnt == M0_LAST);
                    end
                    2'b10: begin
                        m2_cnt  <= (m2_cnt == m2_last) ? 2'd0 : m2_cnt + 2'd1;
                        div_clk <= (m2_cnt == m2_last);
                    end
                    default: begin
                        if (tr1) begin
                            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
                        end
                        if (tick) begin
                            if (tl == 8'hFF) begin
                                tl      <= th1;
                                t1_ovf  <= 1'b1;
                                tog     <= ~tog;
                                div_clk <= smod | tog;
                            end else begin
                                tl <= tl + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Clock-enable generator that sits directly upstream of the serial receiver (and the transmitter).
- Produces the single-cycle `div_clk` oversample strobe the receiver counts 16× per bit, for all four 8051 serial modes (SCON.SM).
- Owns the 8-bit auto-reload baud timer (TH1 reload, SMOD doubling).
- Provides a metastability-hardened copy of the `rxd` pin.

Parameters:
- `TH1_ADDR`, 8'h8D, SFR address of the reload register.
- `PRESCALE`, 12, clk cycles per timer increment in modes 1/3 (≥1).
- `M0_DIV`, 12, clk cycles per `div_clk` in mode 0 (≥1).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `ab`  in  8  SFR address bus
- `db_w`  in  8  SFR write data
- `wrn`  in  1  write strobe, active low
- `scon`  in  8  serial control; bits [7:6] = SM
- `smod`  in  1  baud doubler (PCON.7)
- `tr1`  in  1  baud timer run enable
- `rxd`  in  1  asynchronous serial input pin
- `rxd_s`  out  1  synchronized rxd
- `div_clk`  out  1  oversample strobe, one clk wide
- `t1_ovf`  out  1  timer overflow strobe, one clk wide
- `th1`  out  8  current reload value (readback)

Behaviour:
- Reset is asynchronous, active-high. All registers clear while `rst`=1.
  - `rxd_s`=1, both sync flops=1.
  - `div_clk`=0, `t1_ovf`=0, `th1`=8'h00.
  - TL=8'h00, prescale count=0, mode-0 count=0, mode-2 count=0, overflow toggle=0.
- rxd sync: two-flop synchronizer. `rxd_s` follows `rxd` with 2-clk latency. No filtering.
- TH1 write: on a clk edge with `wrn`=0 and `ab`==`TH1_ADDR`, `th1` <= `db_w`.
  - Writes do not disturb the running TL, which picks up the new value at its next reload.
- Mode 0 (SM=00): counter runs 0..`M0_DIV`-1. `div_clk`=1 in the cycle the count equals `M0_DIV`-1, then it wraps to 0.
  - `M0_DIV`=1 gives `div_clk` constantly high.
  - `tr1` is ignored.
- Mode 2 (SM=10): divide by 2 when `smod`=1, else by 4.
  - Gives a bit period of 32 or 64 clk at the receiver's 16 strobes/bit.
  - `tr1` is ignored.
- Modes 1/3 (SM=01/11):
  - Prescaler counts 0..`PRESCALE`-1 while `tr1`=1. Its wrap is the timer tick.
  - On each tick TL increments. When TL=8'hFF at a tick: TL <= `th1` and `t1_ovf`=1 for that cycle.
  - `smod`=1: `div_clk` = `t1_ovf`.
  - `smod`=0: an overflow toggle flips on each overflow, and `div_clk` = `t1_ovf` && toggle==1, i.e. every 2nd overflow.
  - `tr1`=0: prescaler, TL and toggle hold their values, no strobes. Counting resumes from the held values when `tr1` returns to 1.
- Registered outputs: `div_clk` and `t1_ovf` are registered. The strobe appears the clk after the terminal count is reached, with 1-clk latency fixed across modes.
- Reconfiguration: any change of SM or `smod` versus the previous cycle takes effect on the next edge.
  - All dividers (mode-0 count, mode-2 count, prescaler, toggle) clear.
  - `div_clk` is forced 0 that cycle.
  - TL is not cleared; it is reloaded from `th1`.
  - No partial or runt strobe may be emitted across a mode change.
- Width rules: all counters wrap modulo their terminal count, never modulo 2^n. TL overflow is exactly 8'hFF → `th1`.
  - With `th1`=8'hFF, TL overflows every tick.
- Simultaneous TH1 write and overflow in the same cycle: the reload uses the OLD `th1`; the new value applies from the next reload.
- `rst` asserted mid-count: outputs drop to reset values immediately (asynchronously). First strobe after release follows a full period.

Test Plan:
- Reset/sync: hold `rst` 3 clk with `rxd`=0, release.
  - `rxd_s`=1 during reset and until 2 clk after release, then 0.
  - `div_clk`=0 throughout reset.
- Mode 0: SM=00, `M0_DIV`=12.
  - `div_clk` pulses once every 12 clk: 10 pulses in 120 clk, each exactly 1 clk wide.
- Mode 2: SM=10, `smod`=0.
  - Spacing 4 clk.
  - Toggle `smod`=1: spacing becomes 2 clk, and no pulse in the reconfiguration cycle.
- Mode 1 with `smod`=1, `th1`=8'hFD, `PRESCALE`=12, `tr1`=1:
  - `t1_ovf` every 36 clk; `div_clk` = `t1_ovf`.
  - With `smod`=0: `div_clk` every 72 clk, `t1_ovf` still every 36 clk.
- Run gating: mode 1, deassert `tr1` for 50 clk mid-period.
  - No strobes during that window.
  - The next `t1_ovf` arrives the remaining-count later, not a full period later.
- TH1 write collision: write 8'hF0 to `TH1_ADDR` in the exact overflow cycle with old `th1`=8'hFD.
  - Next period is 3 ticks (old value); the following period is 16 ticks.
  - `th1` reads 8'hF0 one clk after the write.
